// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: owns the PC and steps FETCH/DECODE/EXEC/XWAIT/MEM/WB.
// Optional performance counters are enabled by defining CORE_SEQ_PERF_CNT_EN.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        decode_req,
    output logic        exec_req,
    input  logic [31:0] ex_next_pc,
    input  logic        ex_rd_mem,
    input  logic        ex_wr_mem,
    input  logic        ex_wr_regfile,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam int unsigned WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_XWAIT  = 3'd4,
        ST_MEM    = 3'd5,
        ST_WB     = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         next_pc_q, next_pc_d;
    logic                mem_op_q, mem_op_d;
    logic                wr_rf_q, wr_rf_d;
    logic                wait_expired;

    // Last permitted unacked cycle of a request state; an ack in it still wins.
    assign wait_expired = (WAIT_MAX != 0) && (wait_q == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            pc_q      <= RESET_PC;
            next_pc_q <= '0;
            mem_op_q  <= 1'b0;
            wr_rf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            mem_op_q  <= mem_op_d;
            wr_rf_q   <= wr_rf_d;
        end
    end

    // Next-state logic; wait_d defaults to zero so every state entry clears it.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        mem_op_d  = mem_op_q;
        wr_rf_d   = wr_rf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack)          state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_FAULT;
                else                   wait_d  = wait_q + WAIT_W'(1);
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_XWAIT;
            ST_XWAIT: begin
                next_pc_d = ex_next_pc;
                mem_op_d  = ex_rd_mem | ex_wr_mem;
                wr_rf_d   = ex_wr_regfile;
                if (ex_next_pc[1:0] != 2'b00)       state_d = ST_FAULT;
                else if (ex_rd_mem | ex_wr_mem)     state_d = ST_MEM;
                else                                state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack)          state_d = ST_WB;
                else if (wait_expired) state_d = ST_FAULT;
                else                   wait_d  = wait_q + WAIT_W'(1);
            end
            ST_WB: begin
                pc_d    = next_pc_q;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: state_d = ST_FAULT;
        endcase
    end

    // Outputs decode only registered state, so reset reaches them without a clock.
    always_comb begin
        imem_req   = (state_q == ST_FETCH);
        decode_req = (state_q == ST_DECODE);
        exec_req   = (state_q == ST_EXEC);
        dmem_req   = (state_q == ST_MEM);
        rf_we      = (state_q == ST_WB) && wr_rf_q;
        fault      = (state_q == ST_FAULT);
        imem_addr  = (state_q == ST_FETCH) ? pc_q : 32'h0;
        pc         = pc_q;
        state      = state_q;
    end

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_IDLE && state_q != ST_FAULT) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (state_q == ST_WB) instret_cnt_d = instret_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = 32'h0;
    assign instret_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: an instruction-level model predicts each instruction's outcome.
module tb_core_sequencer;

    localparam int unsigned WMAX   = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b0, run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        ex_rd_mem = 1'b0, ex_wr_mem = 1'b0, ex_wr_regfile = 1'b0;
    logic [31:0] ex_next_pc = 32'h0;
    logic        imem_req, decode_req, exec_req, dmem_req, rf_we, fault;
    logic [31:0] imem_addr, pc, cycle_cnt, instret_cnt;
    logic [2:0]  state;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_m, cyc_m, ret_m;

    core_sequencer #(.RESET_PC(RST_PC), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .decode_req(decode_req), .exec_req(exec_req),
        .ex_next_pc(ex_next_pc), .ex_rd_mem(ex_rd_mem), .ex_wr_mem(ex_wr_mem),
        .ex_wr_regfile(ex_wr_regfile),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .rf_we(rf_we),
        .pc(pc), .state(state), .fault(fault),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef CORE_SEQ_PERF_CNT_EN
        check_eq("cycle_cnt", cycle_cnt, cyc_m);
        check_eq("instret_cnt", instret_cnt, ret_m);
`else
        check_eq("cycle_cnt_tied", cycle_cnt, 32'h0);
        check_eq("instret_cnt_tied", instret_cnt, 32'h0);
`endif
    endtask

    // Called just after a rising edge; asserts reset mid-cycle with acks still pending.
    task automatic do_reset();
        #3 reset = 1'b1;
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_strobes", 32'({imem_req, dmem_req, decode_req, exec_req, rf_we, fault}), 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        run = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        pc_m = RST_PC; cyc_m = 32'd0; ret_m = 32'd0;
        imem_ack = 1'b1; dmem_ack = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_idle", 32'(state), 32'd0);
        check_perf();
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    // ack_f / ack_d: unacked cycles before the ack. drop: run falls mid-instruction.
    task automatic run_instr(input int ack_f, input logic [31:0] npc, input logic rd,
                             input logic wr, input logic wrf, input int ack_d, input logic drop);
        int fc = 0, dc = 0, decs = 0, exs = 0, wes = 0, cyc = 0, addr_bad = 0;
        int fcy_e, dcy_e, lat_e;
        logic prev_wb = 1'b0;
        logic fto, mis, memop, dto, ok;
        logic [2:0]  end_e;
        logic [31:0] pc_e, junk;

        fto   = (ack_f >= int'(WMAX));
        fcy_e = fto ? int'(WMAX) : ack_f + 1;
        mis   = !fto && (npc[1:0] != 2'b00);
        memop = rd | wr;
        dto   = !fto && !mis && memop && (ack_d >= int'(WMAX));
        dcy_e = (!fto && !mis && memop) ? (dto ? int'(WMAX) : ack_d + 1) : 0;
        ok    = !fto && !mis && !dto;
        lat_e = fcy_e + (fto ? 0 : 3) + dcy_e + (ok ? 1 : 0);
        pc_e  = ok ? npc : pc_m;
        end_e = ok ? (drop ? 3'd0 : 3'd1) : 3'd7;

        run = 1'b1;
        if (state == 3'd0) begin
            @(posedge clk); #1;
        end
        check_eq("entry_state", 32'(state), 32'd1);

        while (cyc < 64) begin
            if (cyc > 0 && (state == 3'd7 || prev_wb)) break;
            prev_wb = (state == 3'd6);
            if (imem_req) begin
                fc++;
                imem_ack = (fc > ack_f);
                if (imem_addr !== pc_m) addr_bad++;
            end else begin
                imem_ack = 1'($urandom);
                if (imem_addr !== 32'h0) addr_bad++;
            end
            if (dmem_req) begin
                dc++;
                dmem_ack = (dc > ack_d);
            end else begin
                dmem_ack = 1'($urandom);
            end
            if (decode_req) decs++;
            if (exec_req) exs++;
            if (rf_we) wes++;
            if (drop && (dmem_req || (exec_req && !memop))) run = 1'b0;
            // Only the XWAIT cycle carries real execute results.
            if (state == 3'd4) begin
                ex_next_pc = npc; ex_rd_mem = rd; ex_wr_mem = wr; ex_wr_regfile = wrf;
            end else begin
                junk = $urandom;
                ex_next_pc = junk; ex_rd_mem = junk[0]; ex_wr_mem = junk[1]; ex_wr_regfile = junk[2];
            end
            @(posedge clk); #1;
            cyc++;
        end

        check_eq("latency", 32'(cyc), 32'(lat_e));
        check_eq("imem_req_cycles", 32'(fc), 32'(fcy_e));
        check_eq("dmem_req_cycles", 32'(dc), 32'(dcy_e));
        check_eq("decode_pulses", 32'(decs), fto ? 32'd0 : 32'd1);
        check_eq("exec_pulses", 32'(exs), fto ? 32'd0 : 32'd1);
        check_eq("rf_we_pulses", 32'(wes), (ok && wrf) ? 32'd1 : 32'd0);
        check_eq("imem_addr_errs", 32'(addr_bad), 32'd0);
        check_eq("pc", pc, pc_e);
        check_eq("end_state", 32'(state), 32'(end_e));
        check_eq("fault", 32'(fault), (end_e == 3'd7) ? 32'd1 : 32'd0);
        pc_m  = pc_e;
        cyc_m = cyc_m + 32'(lat_e);
        ret_m = ret_m + (ok ? 32'd1 : 32'd0);
        check_perf();

        if (end_e == 3'd7) begin
            // FAULT is terminal: stray acks and run toggles change nothing.
            for (int i = 0; i < 4; i++) begin
                run = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
                @(posedge clk); #1;
                check_eq("fault_hold", 32'({state, imem_req, dmem_req, decode_req, exec_req, rf_we, fault}),
                         32'({3'd7, 5'b00000, 1'b1}));
                check_eq("fault_pc", pc, pc_m);
            end
            check_perf();
            do_reset();
        end
    endtask

    // Drive a load into MEM, then reset while dmem_req is still high.
    task automatic reset_mid_mem();
        int n = 0;
        run = 1'b1;
        while (!dmem_req && n < 12) begin
            imem_ack = imem_req; dmem_ack = 1'b0;
            ex_next_pc = pc + 32'd4; ex_rd_mem = 1'b1; ex_wr_mem = 1'b0; ex_wr_regfile = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check_eq("reached_mem", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, npc;
        int ack_f, ack_d;
        logic rd, wr, wrf, drop;

        @(posedge clk); #1;
        do_reset();

        // Basic non-memory instruction, then three back-to-back for the counters.
        run_instr(0, RST_PC + 32'd4, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_instr(0, pc_m + 32'd4, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_instr(0, pc_m + 32'd4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
`ifdef CORE_SEQ_PERF_CNT_EN
        check_eq("perf_cycles_3instr", cycle_cnt, 32'd15);
        check_eq("perf_instret_3instr", instret_cnt, 32'd3);
`endif
        // Load acked in the 3rd MEM cycle, run dropped during MEM.
        run_instr(0, pc_m + 32'd4, 1'b1, 1'b0, 1'b1, 2, 1'b1);
        // Fetch ack on the last allowed cycle, store ack on the last allowed cycle.
        run_instr(int'(WMAX) - 1, pc_m + 32'd8, 1'b0, 1'b1, 1'b0, int'(WMAX) - 1, 1'b0);
        // Misaligned target, fetch timeout, data timeout.
        run_instr(0, 32'h0000_0102, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_instr(int'(WMAX), pc_m + 32'd4, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_instr(1, pc_m + 32'd4, 1'b1, 1'b0, 1'b1, int'(WMAX), 1'b0);
        reset_mid_mem();

        for (int t = 0; t < 60; t++) begin
            r     = $urandom;
            ack_f = (r[3:0] == 4'd0) ? int'(WMAX) : int'($urandom_range(0, WMAX - 1));
            ack_d = (r[7:4] == 4'd0) ? int'(WMAX) + 1 : int'($urandom_range(0, WMAX - 1));
            npc   = $urandom;
            npc   = (r[11:8] == 4'd0) ? (npc | 32'd1) : (npc & 32'hFFFF_FFFC);
            rd    = r[12];
            wr    = r[13] & ~r[12];
            wrf   = r[14];
            drop  = (r[17:15] == 3'd0);
            run_instr(ack_f, npc, rd, wr, wrf, ack_d, drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It owns the architectural PC and steps each instruction through fetch, decode, execute, memory and write-back. It issues the `req` pulse to the execute stage, samples that stage's control outputs, and runs the instruction- and data-memory handshakes. It sits above the fetch, decode, exec and regfile blocks and is the only writer of `pc`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `WAIT_MAX`, 15, maximum cycles to wait for `imem_ack`/`dmem_ack` before faulting; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `run` in 1: level; 1 allows new instructions to start.
- `imem_req` out 1: instruction fetch request, held until ack.
- `imem_addr` out 32: equals `pc` while `imem_req`=1, else 0.
- `imem_ack` in 1: fetch complete; instruction word is valid this cycle.
- `decode_req` out 1: one-cycle pulse to decode/regfile read.
- `exec_req` out 1: one-cycle pulse to the execute stage `req`.
- `ex_next_pc` in 32: execute-stage next PC.
- `ex_rd_mem` in 1: execute-stage load flag.
- `ex_wr_mem` in 1: execute-stage store flag.
- `ex_wr_regfile` in 1: execute-stage write-back flag.
- `dmem_req` out 1: data memory request, held until ack.
- `dmem_ack` in 1: data access complete.
- `rf_we` out 1: one-cycle regfile write enable.
- `pc` out 32: architectural PC.
- `state` out 3: current FSM state encoding.
- `fault` out 1: sticky error flag.
- `cycle_cnt` out 32: active-cycle counter (see Configuration).
- `instret_cnt` out 32: retired-instruction counter (see Configuration).

## Operation
States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, XWAIT=4, MEM=5, WB=6, FAULT=7.
- IDLE: `run`=1 → FETCH; otherwise stay.
- FETCH: `imem_req`=1. On `imem_ack`=1 → DECODE. After WAIT_MAX FETCH cycles with no ack → FAULT.
- DECODE: `decode_req`=1 → EXEC.
- EXEC: `exec_req`=1 → XWAIT.
- XWAIT: latch `ex_next_pc`, `ex_rd_mem|ex_wr_mem`, `ex_wr_regfile` at the end of this cycle.
  - If `ex_next_pc[1:0]`≠0 → FAULT; `pc` is unchanged.
  - Else if memory op → MEM.
  - Else → WB.
- MEM: `dmem_req`=1. On `dmem_ack` → WB. After WAIT_MAX cycles with no ack → FAULT.
- WB:
  - `rf_we` = latched `ex_wr_regfile`.
  - `pc` <= latched next PC; instruction retires.
  - `run`=1 → FETCH, else IDLE.
- FAULT: `fault`=1; all requests 0. Terminal until reset.

Handshake and state rules:
- An ack in the first cycle of a request state is legal and completes that state in one cycle.
- Acks outside FETCH/MEM are ignored.
- The wait counter is cleared on every state entry.
- Deasserting `run` never aborts an instruction in flight; the FSM returns to IDLE only from WB.

## Timing
- Reset (async): `state`=IDLE, `pc`=RESET_PC, `fault`=0, counters 0, every request/strobe output 0. Outputs change immediately, without a clock edge.
- All outputs are registered or decoded from `state` only; no input-to-output combinational path.
- Minimum latency:
  - Non-memory instruction: 5 cycles (FETCH→WB).
  - Load/store: 6 cycles.
  - Each extra ack wait adds 1 cycle.
- Timeout: with WAIT_MAX=N, FAULT is entered on the edge ending the Nth unacked cycle. An ack in the Nth cycle wins over the timeout.
- Reset mid-MEM or mid-FETCH: requests drop to 0 asynchronously; the pending ack is discarded.
- `pc` arithmetic is 32-bit; wrap at 2^32 is not special-cased. Alignment is the only check.

## Configuration
- `CORE_SEQ_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle the state is neither IDLE nor FAULT.
  - `instret_cnt` increments in each WB cycle.
  - Both are 32-bit, wrap to 0, and are cleared by reset.
- Not defined: both ports are tied to 32'h0 and no counter flops exist.

## Test plan
- Reset, `run`=1, `imem_ack`=1, `ex_next_pc`=pc+4, no memory op → `state` sequence 1,2,3,4,6,1; `pc` 0→4 after 5 cycles; single `rf_we` pulse in WB.
- Load (`ex_rd_mem`=1), `dmem_ack` asserted on the 3rd MEM cycle → `dmem_req` high exactly 3 cycles; WB follows; `pc` updated once.
- WAIT_MAX=4, `imem_ack`=0 → FAULT after 4 FETCH cycles; `fault`=1, `imem_req`=0. Further acks and `run` toggles are ignored.
- `ex_next_pc`=32'h0000_0102 in XWAIT → FAULT; `pc` keeps its old value; `rf_we` never pulses.
- `run` dropped during MEM → instruction completes WB, then IDLE. Reset asserted mid-MEM → `dmem_req`=0 and `state`=0 without a clock edge; `pc`=RESET_PC.
- With `CORE_SEQ_PERF_CNT_EN`: three back-to-back non-memory instructions, instant acks → `instret_cnt`=3, `cycle_cnt`=15 on entering the 4th FETCH.
